// File: rtl/mul_div_seq_pkg.sv
// Shared constants for the iterative M-extension unit: funct3 opcodes,
// FSM state encodings and the default operand width.
package mul_div_seq_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Final result shaping: conditional negate of the unsigned product,
// quotient or remainder, then selection of the architectural result.
module md_sign_fix
  import mul_div_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]        op,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);

  logic              neg_prod;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Signs are already zero for operands treated as unsigned, so only MULHSU
  // needs special handling (its rs2 sign never contributes).
  always_comb begin
    neg_prod = (op == F3_MULHSU) ? sign_a : (sign_a ^ sign_b);
    prod     = neg_prod ? -acc : acc;
    quot     = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem      = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:                      result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             result = quot;
      default:                     result = rem;
    endcase
  end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative RV32M/RV64M multiply/divide unit, one result bit per cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// MD_IDLE | waiting for iStart
// MD_CALC | XLEN shift-add (mul) or restoring-divide (div) iterations
// MD_FIX  | sign correction and result select, oResult registered
// MD_DONE | oDone pulse; a new start may be accepted in this cycle
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic            iFlush,
  input  logic [2:0]      iOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   result;

  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   fix_result;

  // Acceptance decode: operand signs/magnitudes and the cases that skip CALC
  always_comb begin
    accept   = iStart && !iFlush && (state == MD_IDLE || state == MD_DONE);
    a_neg    = iA[XLEN-1] && (iOp == F3_MULH || iOp == F3_MULHSU ||
                              iOp == F3_DIV  || iOp == F3_REM);
    b_neg    = iB[XLEN-1] && (iOp == F3_MULH || iOp == F3_DIV || iOp == F3_REM);
    mag_a    = a_neg ? -iA : iA;
    mag_b    = b_neg ? -iB : iB;
    div_zero = is_div(iOp) && (iB == '0);
    div_ovf  = (iOp == F3_DIV || iOp == F3_REM) &&
               (iA == {1'b1, {(XLEN-1){1'b0}}}) && (iB == '1);
    // funct3[1] distinguishes remainder from quotient within the divide family
    if (div_zero) special_res = iOp[1] ? iA : '1;
    else          special_res = iOp[1] ? '0 : iA;
  end

  // One iteration: acc = {hi, multiplier} for mul, {remainder, quotient} for div
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (is_div(op_q))
      acc_next = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
  end

  md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op     (op_q),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .acc    (acc),
    .result (fix_result)
  );

  // Control FSM and datapath registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      case (state)
        MD_IDLE, MD_DONE: begin
          if (accept) begin
            op_q   <= iOp;
            sign_a <= a_neg;
            sign_b <= b_neg;
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= MD_DONE;
            end else begin
              cnt   <= CNT_W'(XLEN);
              acc   <= {{XLEN{1'b0}}, is_div(iOp) ? mag_a : mag_b};
              opnd  <= is_div(iOp) ? mag_b : mag_a;
              state <= MD_CALC;
            end
          end else begin
            state <= MD_IDLE;
          end
        end
        MD_CALC: begin
          if (iFlush) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (iFlush) begin
            state <= MD_IDLE;
          end else begin
            result <= fix_result;
            state  <= MD_DONE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign oBusy   = (state == MD_CALC) || (state == MD_FIX);
  assign oDone   = (state == MD_DONE);
  assign oResult = result;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq (XLEN=32): directed vectors, handshake
// corner cases and randomized operations against an arithmetic model.
module tb_mul_div_seq;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic        iFlush = 1'b0;
  logic [2:0]  iOp = 3'd0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_seq #(.XLEN(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush),
    .iOp(iOp), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  // Reference model from the ISA definition using wide integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Observe until oDone (bounded); counts cycles where oBusy was low before done
  task automatic wait_done(output int lat, output logic [31:0] res, output int busy_bad);
    lat = -1; res = 'x; busy_bad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge iCLK);
      if (oDone) begin lat = n; res = oResult; break; end
      if (!oBusy) busy_bad++;
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int busy_bad);
    @(negedge iCLK);
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    @(posedge iCLK); #1;
    iStart = 1'b0; iOp = 3'($urandom); iA = $urandom; iB = $urandom;
    wait_done(lat, res, busy_bad);
  endtask

  task automatic test_reset();
    iStart = 1'b1; iOp = 3'd0; iA = 32'd3; iB = 32'd4;
    repeat (3) @(negedge iCLK);
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b result=%h required 0/0/00000000", oBusy, oDone, oResult);
    end
    iStart = 1'b0; iRST = 1'b0;
    @(negedge iCLK);
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%b done=%b required 0/0", oBusy, oDone);
    end
  endtask

  logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd100,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd2, 32'd7,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
  int          d_lat[12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

  task automatic test_directed();
    int lat, bb;
    logic [31:0] res;
    for (int i = 0; i < 12; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], lat, res, bb);
      n_cmp++;
      if (res !== d_exp[i]) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got %h required %h", i, res, d_exp[i]);
      end
      n_cmp++;
      if (lat != d_lat[i] || bb != 0) begin
        n_bad++;
        $display("FAIL directed_timing[%0d]: latency %0d busy_low %0d required %0d/0",
                 i, lat, bb, d_lat[i]);
      end
      @(negedge iCLK);
      n_cmp++;
      if (oDone !== 1'b0) begin
        n_bad++;
        $display("FAIL done_pulse[%0d]: done=%b required 0", i, oDone);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [31:0] res;
    @(negedge iCLK);
    iStart = 1'b1; iOp = 3'd0; iA = 32'd3; iB = 32'd4;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    lat = -1; res = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(negedge iCLK);
      iStart = (n == 10);
      if (n == 10) begin iOp = 3'd5; iA = 32'd55; iB = 32'd66; end
      if (oDone) begin lat = n; res = oResult; break; end
    end
    iStart = 1'b0;
    n_cmp++;
    if (res !== 32'd12 || lat != 34) begin
      n_bad++;
      $display("FAIL ignore_start: result %h latency %0d required 0000000c/34", res, lat);
    end
    @(negedge iCLK);
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start_idle: busy=%b done=%b required 0/0", oBusy, oDone);
    end
  endtask

  task automatic test_flush();
    int dones;
    @(negedge iCLK);
    iStart = 1'b1; iOp = 3'd0; iA = 32'd5; iB = 32'd6;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    repeat (5) @(negedge iCLK);
    iFlush = 1'b1;
    @(posedge iCLK); #1;
    iFlush = 1'b0;
    @(negedge iCLK);
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd12) begin
      n_bad++;
      $display("FAIL flush: busy=%b done=%b result=%h required 0/0/0000000c", oBusy, oDone, oResult);
    end
    dones = 0;
    repeat (40) begin @(negedge iCLK); if (oDone || oBusy) dones++; end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL flush_quiet: active cycles %0d required 0", dones);
    end
    iStart = 1'b1; iFlush = 1'b1; iOp = 3'd0; iA = 32'd9; iB = 32'd9;
    @(posedge iCLK); #1;
    iStart = 1'b0; iFlush = 1'b0;
    @(negedge iCLK);
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd12) begin
      n_bad++;
      $display("FAIL flush_drops_start: busy=%b done=%b result=%h required 0/0/0000000c",
               oBusy, oDone, oResult);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge iCLK);
    iStart = 1'b1; iOp = 3'd5; iA = 32'd1000; iB = 32'd7;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    repeat (10) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h required 0/0/00000000", oBusy, oDone, oResult);
    end
    iRST = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    logic [31:0] res;
    do_op(3'd0, 32'd3, 32'd4, lat, res, bb);
    n_cmp++;
    if (res !== 32'd12 || lat != 34) begin
      n_bad++;
      $display("FAIL b2b_first: result %h latency %0d required 0000000c/34", res, lat);
    end
    iStart = 1'b1; iOp = 3'd5; iA = 32'd9; iB = 32'd3;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    wait_done(lat, res, bb);
    n_cmp++;
    if (res !== 32'd3 || lat != 34 || bb != 0) begin
      n_bad++;
      $display("FAIL b2b_second: result %h latency %0d busy_low %0d required 00000003/34/0",
               res, lat, bb);
    end
  endtask

  task automatic test_random();
    int lat, bb, pick;
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) b = 32'h0;
      else if (pick == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (pick == 2) b = 32'($urandom_range(1, 20));
      else if (pick == 3) b = -32'($urandom_range(1, 20));
      exp = ref_md(op, a, b);
      do_op(op, a, b, lat, res, bb);
      n_cmp++;
      if (res !== exp || lat != ref_lat(op, a, b) || bb != 0) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: result %h latency %0d busy_low %0d required %h/%0d/0",
                 i, op, a, b, res, lat, bb, exp, ref_lat(op, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
Name: mul_div_seq

Overview:
- Iterative RV32M/RV64M multiply/divide unit with a start/done handshake, one result bit per cycle.
- Replaces the single-cycle combinational `*`, `/` and `%` paths of the integer ALU so the M extension closes timing in the multicycle and pipelined cores.
- Sits beside the ALU. The control unit stalls the pipeline while oBusy=1.
- Adds RISC-V-compliant divide-by-zero and signed-overflow results, plus pipeline flush.

Parameters:
- XLEN, 32, operand/result width; legal values 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- iCLK  in  1  core clock
- iRST  in  1  synchronous, active-high reset
- iStart  in  1  request; accepted only when oBusy=0
- iFlush  in  1  abort the operation in flight; no oDone
- iOp  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- iA  in  XLEN  rs1 operand (dividend / multiplicand)
- iB  in  XLEN  rs2 operand (divisor / multiplier)
- oBusy  out  1  high in CALC and FIX states
- oDone  out  1  one-cycle pulse; oResult valid in that cycle
- oResult  out  XLEN  result; held until the next accepted start

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset/iRST → IDLE with oBusy=0, oDone=0, oResult=0, counter=0, internal registers=0.
- IDLE or DONE, iStart=1 at edge k (the start is accepted):
  - Latch op, operand signs and magnitudes. Signed ops take the absolute value; MULHSU treats only iA as signed.
  - Set counter to XLEN and enter CALC.
- Special case at acceptance (bypasses CALC):
  - DIV/DIVU/REM/REMU with iB=0, or DIV/REM with iA=INT_MIN and iB=−1: go directly to DONE.
  - oDone at cycle k+1.
- Multiply in CALC:
  - Unsigned shift-add on a 2·XLEN accumulator.
  - Each cycle: if multiplier LSB=1, add multiplicand to the upper half; shift right 1.
- Divide in CALC:
  - Restoring division. Each cycle shift {rem,quot} left 1, trial-subtract divisor.
  - Quotient bit = 1 if no borrow (keep the difference), else restore.
- Counter decrements each CALC cycle. CALC lasts exactly XLEN cycles, then FIX.
- FIX (1 cycle): apply sign correction and result selection, register oResult, go to DONE.
  - Product is negated if signA^signB; for MULHSU, if signA.
  - MUL → low XLEN bits; MULH/MULHSU/MULHU → high XLEN bits.
  - Quotient is negated if signA^signB (DIV). Remainder takes signA (REM).
- Normal latency: start accepted at edge k → oDone high in cycle k+XLEN+2 (XLEN=32: 34).
- DONE (1 cycle): oDone=1, oBusy=0. Next state is IDLE, or CALC/DONE if a new iStart is accepted in the same cycle (back-to-back, no bubble).
- Special results:
  - DIV/DIVU by 0 → all ones; REM/REMU by 0 → iA.
  - DIV INT_MIN/−1 → INT_MIN; REM INT_MIN/−1 → 0.
- iStart while oBusy=1 is ignored; operands are not re-sampled.
- iFlush=1 in CALC or FIX → IDLE next cycle; oDone stays 0; oResult keeps its previous value. iFlush in IDLE or DONE has no effect on state; a simultaneous iStart is dropped.
- iRST has priority over iFlush, and iFlush over iStart.
- Mid-operation iRST → IDLE next edge, all outputs 0.
- iOp, iA and iB are don't-care except at the acceptance edge.

Decomposition:
- Add to the shared parameters header (same guard/include scheme as the ALU opcodes):
  - funct3 constants for the M ops
  - MD_IDLE/MD_CALC/MD_FIX/MD_DONE state encodings
  - an XLEN default
- One sub-module, md_sign_fix (combinational): conditional two's-complement negate plus hi/lo/quot/rem select, parametrised by XLEN. Used in FIX.
- Datapath and FSM remain in mul_div_seq.

Test Plan (XLEN=32):
- MUL iA=7, iB=0xFFFFFFFD (−3) → oResult=0xFFFFFFEB. oDone exactly 34 cycles after the start edge; oBusy high cycles 1–33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both with oDone 1 cycle after start. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Start MUL 3×4, pulse iStart with other operands at cycle 10 (ignored); result is 12. Start again, iFlush at cycle 5 → no oDone, oBusy=0 next cycle, oResult still 12. iRST mid-CALC → all outputs 0.
- Back-to-back: iStart with DIVU 9/3 in the MUL's DONE cycle → 3 delivered 34 cycles later, with no idle bubble.
